// File: rtl/johnson_step_ctrl_if.sv
// rtl/johnson_step_ctrl_if.sv - command/status bundle for the Johnson step controller
interface johnson_step_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_div;
    logic             abort;
    logic [WIDTH-1:0] phase_out;
    logic             busy;
    logic             done;
    logic             abort_ack;
    logic [CNT_W-1:0] steps_left;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_div, abort,
        input  cmd_ready, phase_out, busy, done, abort_ack, steps_left
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_div, abort,
        output cmd_ready, phase_out, busy, done, abort_ack, steps_left
    );
endinterface

// File: rtl/johnson_step_ctrl.sv
// rtl/johnson_step_ctrl.sv - Johnson-code stepper phase controller; JOHNSON_STEP_CTRL_IDLE_OFF_EN blanks phase_out outside RUN
module johnson_step_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    johnson_step_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_ABORTED = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] phase, phase_nxt;
    logic [CNT_W-1:0] steps_left, steps_nxt;
    logic [DIV_W-1:0] timer, timer_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic             dir_q, dir_nxt;
    logic [WIDTH-1:0] phase_fwd, phase_rev;

    // Both directions are single shifts of a Johnson code, so only legal codes are reachable.
    assign phase_fwd = {~phase[0], phase[WIDTH-1:1]};
    assign phase_rev = {phase[WIDTH-2:0], ~phase[WIDTH-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            phase      <= '0;
            steps_left <= '0;
            timer      <= '0;
            div_q      <= '0;
            dir_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            steps_left <= steps_nxt;
            timer      <= timer_nxt;
            div_q      <= div_nxt;
            dir_q      <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        steps_nxt = steps_left;
        timer_nxt = timer;
        div_nxt   = div_q;
        dir_nxt   = dir_q;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    dir_nxt   = bus.cmd_dir;
                    div_nxt   = bus.cmd_div;
                    steps_nxt = bus.cmd_steps;
                    timer_nxt = bus.cmd_div;
                    state_nxt = (bus.cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over a step that would fall due on the same edge.
                if (bus.abort) begin
                    state_nxt = S_ABORTED;
                end else if (timer == '0) begin
                    phase_nxt = dir_q ? phase_fwd : phase_rev;
                    steps_nxt = steps_left - 1'b1;
                    timer_nxt = div_q;
                    if (steps_left == CNT_W'(1))
                        state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_DONE:    state_nxt = S_IDLE;
            S_ABORTED: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.busy       = (state == S_RUN);
    assign bus.done       = (state == S_DONE);
    assign bus.abort_ack  = (state == S_ABORTED);
    assign bus.steps_left = steps_left;

`ifdef JOHNSON_STEP_CTRL_IDLE_OFF_EN
    assign bus.phase_out = (state == S_RUN) ? phase : '0;
`else
    assign bus.phase_out = phase;
`endif

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// tb/tb_johnson_step_ctrl.sv - directed self-checking bench for johnson_step_ctrl
module tb_johnson_step_ctrl;
    localparam int WIDTH = 4;
    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
`ifdef JOHNSON_STEP_CTRL_IDLE_OFF_EN
    localparam bit IDLE_OFF = 1'b1;
`else
    localparam bit IDLE_OFF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    johnson_step_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

    johnson_step_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [3:0] flags();
        return {bus.cmd_ready, bus.busy, bus.done, bus.abort_ack};
    endfunction

    // Called at a falling edge; the command is taken on the following rising edge.
    task automatic issue(input logic d, input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] v);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = d;
        bus.cmd_steps = s;
        bus.cmd_div   = v;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_steps = '0; bus.cmd_div = '0; bus.abort = 1'b0;
        rst = 1'b0;
        #2;
        n_checks++;
        if (flags() !== 4'b1000) begin n_fail++; $display("FAIL reset_flags: got %b expected 1000", flags()); end
        n_checks++;
        if (bus.steps_left !== 16'd0) begin n_fail++; $display("FAIL reset_steps: got %0d expected 0", bus.steps_left); end
        n_checks++;
        if (bus.phase_out !== 4'b0000) begin n_fail++; $display("FAIL reset_phase: got %b expected 0000", bus.phase_out); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_forward8();
        logic [3:0] seq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        logic [3:0] ef;
        issue(1'b1, 16'd8, 16'd0);
        n_checks++;
        if (flags() !== 4'b0100 || bus.steps_left !== 16'd8 || bus.phase_out !== 4'b0000) begin
            n_fail++; $display("FAIL fwd_accept: got flags %b steps %0d phase %b expected 0100 8 0000", flags(), bus.steps_left, bus.phase_out);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ef = (i == 7) ? 4'b0010 : 4'b0100;
            n_checks++;
            if (bus.phase_out !== (IDLE_OFF && i == 7 ? 4'b0000 : seq[i])) begin
                n_fail++; $display("FAIL fwd_phase[%0d]: got %b expected %b", i, bus.phase_out, seq[i]);
            end
            n_checks++;
            if (bus.steps_left !== 16'(7 - i) || flags() !== ef) begin
                n_fail++; $display("FAIL fwd_state[%0d]: got steps %0d flags %b expected %0d %b", i, bus.steps_left, flags(), 7 - i, ef);
            end
        end
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000 || bus.steps_left !== 16'd0) begin
            n_fail++; $display("FAIL fwd_idle: got flags %b steps %0d expected 1000 0", flags(), bus.steps_left);
        end
    endtask

    task automatic test_reverse3();
        logic [3:0] ep, ef;
        logic [15:0] es;
        int busy_cnt = 0;
        issue(1'b0, 16'd3, 16'd2);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            ep = (k < 3) ? 4'b0000 : (k < 6) ? 4'b0001 : (k < 9) ? 4'b0011 : (IDLE_OFF ? 4'b0000 : 4'b0111);
            es = (k < 3) ? 16'd3 : (k < 6) ? 16'd2 : (k < 9) ? 16'd1 : 16'd0;
            ef = (k < 9) ? 4'b0100 : 4'b0010;
            n_checks++;
            if (bus.phase_out !== ep || bus.steps_left !== es || flags() !== ef) begin
                n_fail++; $display("FAIL rev_cycle[%0d]: got phase %b steps %0d flags %b expected %b %0d %b", k, bus.phase_out, bus.steps_left, flags(), ep, es, ef);
            end
        end
        n_checks++;
        if (busy_cnt !== 9) begin n_fail++; $display("FAIL rev_busy_cycles: got %0d expected 9", busy_cnt); end
        @(negedge clk);
    endtask

    task automatic test_zero_steps();
        logic [3:0] ep;
        ep = IDLE_OFF ? 4'b0000 : 4'b0111;
        bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_steps = 16'd0; bus.cmd_div = 16'd5;
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b0010 || bus.phase_out !== ep) begin
            n_fail++; $display("FAIL zero_done: got flags %b phase %b expected 0010 %b", flags(), bus.phase_out, ep);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000 || bus.phase_out !== ep) begin
            n_fail++; $display("FAIL zero_ignore_in_done: got flags %b phase %b expected 1000 %b", flags(), bus.phase_out, ep);
        end
        bus.cmd_valid = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000) begin n_fail++; $display("FAIL zero_idle: got flags %b expected 1000", flags()); end
    endtask

    task automatic test_abort();
        issue(1'b1, 16'd10, 16'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6 || k == 7) begin
                n_checks++;
                if (bus.phase_out !== 4'b0000 || bus.steps_left !== 16'd7 || flags() !== 4'b0100) begin
                    n_fail++; $display("FAIL abort_run[%0d]: got phase %b steps %0d flags %b expected 0000 7 0100", k, bus.phase_out, bus.steps_left, flags());
                end
            end
        end
        bus.abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b0001 || bus.steps_left !== 16'd7 || bus.phase_out !== 4'b0000) begin
            n_fail++; $display("FAIL abort_ack: got flags %b steps %0d phase %b expected 0001 7 0000", flags(), bus.steps_left, bus.phase_out);
        end
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000 || bus.steps_left !== 16'd7 || bus.phase_out !== 4'b0000) begin
            n_fail++; $display("FAIL abort_idle: got flags %b steps %0d phase %b expected 1000 7 0000", flags(), bus.steps_left, bus.phase_out);
        end
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000) begin n_fail++; $display("FAIL abort_in_idle: got flags %b expected 1000", flags()); end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        issue(1'b1, 16'd8, 16'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.steps_left !== 16'd5 || bus.phase_out !== 4'b1110) begin
            n_fail++; $display("FAIL rstmid_pre: got steps %0d phase %b expected 5 1110", bus.steps_left, bus.phase_out);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (flags() !== 4'b1000 || bus.steps_left !== 16'd0 || bus.phase_out !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_async: got flags %b steps %0d phase %b expected 1000 0 0000", flags(), bus.steps_left, bus.phase_out);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (flags() !== 4'b1000) begin n_fail++; $display("FAIL rstmid_hold[%0d]: got flags %b expected 1000", k, flags()); end
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flags() !== 4'b1000) begin n_fail++; $display("FAIL rstmid_release: got flags %b expected 1000", flags()); end
    endtask

    task automatic test_idle_phase();
        logic [3:0] ep;
        issue(1'b1, 16'd2, 16'd0);
        repeat (3) @(negedge clk);
        ep = IDLE_OFF ? 4'b0000 : 4'b1100;
        n_checks++;
        if (flags() !== 4'b1000 || bus.phase_out !== ep) begin
            n_fail++; $display("FAIL idle_phase: got flags %b phase %b expected 1000 %b", flags(), bus.phase_out, ep);
        end
        issue(1'b1, 16'd2, 16'd1);
        n_checks++;
        if (bus.phase_out !== 4'b1100) begin n_fail++; $display("FAIL resume_phase: got %b expected 1100", bus.phase_out); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.phase_out !== 4'b1110 || flags() !== 4'b0100) begin
            n_fail++; $display("FAIL resume_step: got phase %b flags %b expected 1110 0100", bus.phase_out, flags());
        end
        repeat (2) @(negedge clk);
        ep = IDLE_OFF ? 4'b0000 : 4'b1111;
        n_checks++;
        if (bus.phase_out !== ep || flags() !== 4'b0010) begin
            n_fail++; $display("FAIL resume_done: got phase %b flags %b expected %b 0010", bus.phase_out, flags(), ep);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_forward8();
        test_reverse3();
        test_zero_steps();
        test_abort();
        test_reset_mid_move();
        test_idle_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/johnson_step_ctrl.md
JOHNSON_STEP_CTRL -- requirements
Module: johnson_step_ctrl

Interface
REQ-001 Parameter WIDTH, 4: Johnson phase register width; legal range 2..16.
REQ-002 Parameter CNT_W, 16: step-count width.
REQ-003 Parameter DIV_W, 16: step-rate divider width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  move command offered.
REQ-007 cmd_ready  output  1  controller can accept a command.
REQ-008 cmd_dir  input  1  1 = forward, 0 = reverse.
REQ-009 cmd_steps  input  CNT_W  number of phase steps to issue.
REQ-010 cmd_div  input  DIV_W  step period minus one, in clk cycles.
REQ-011 abort  input  1  terminate the active move.
REQ-012 phase_out  output  WIDTH  Johnson phase drive.
REQ-013 busy  output  1  move in progress.
REQ-014 done  output  1  one-cycle pulse on normal move completion.
REQ-015 abort_ack  output  1  one-cycle pulse on aborted move.
REQ-016 steps_left  output  CNT_W  steps remaining in current or last move.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE, ABORTED, registered, one-hot or binary.
REQ-018 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN.
REQ-019 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; dir, steps, div are latched at that edge.
REQ-020 On acceptance with cmd_steps=0: IDLE->DONE, no phase change.
REQ-021 On acceptance with cmd_steps>0: IDLE->RUN, steps_left=cmd_steps, timer=cmd_div.
REQ-022 In RUN, the timer SHALL decrement each cycle; when timer=0 one step is taken, steps_left decrements, and timer reloads the latched div.
REQ-023 Step period SHALL be div+1 cycles; first step on the (div+1)th edge after acceptance; div=0 gives one step per cycle.
REQ-024 Forward step: phase <= {~phase[0], phase[WIDTH-1:1]}; reverse step: phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}; sequence period 2*WIDTH, wraps in both directions.
REQ-025 When the step taking steps_left from 1 to 0 occurs, RUN->DONE on the same edge.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-027 abort=1 in RUN SHALL move to ABORTED on the next edge; any step due on that edge is suppressed; steps_left holds.
REQ-028 ABORTED SHALL assert abort_ack for exactly one cycle, then go to IDLE; done is not asserted.
REQ-029 abort in IDLE, DONE or ABORTED SHALL be ignored; cmd_valid outside IDLE SHALL be ignored.
REQ-030 The internal phase register SHALL persist across commands; only reset clears it.
REQ-031 Only the 2*WIDTH legal Johnson codes SHALL ever appear on the internal phase register.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, phase 0, steps_left 0, timer 0, done 0, abort_ack 0, busy 0, cmd_ready 1.
REQ-033 Reset asserted mid-move SHALL discard the move with no done or abort_ack pulse.
REQ-034 Release SHALL be synchronous to clk; first command acceptable on the first edge with rst=1.

Configuration
REQ-035 Macro JOHNSON_STEP_CTRL_IDLE_OFF_EN: when defined, phase_out SHALL be all-zero whenever state is not RUN, while the internal phase is retained and reappears on entry to RUN.
REQ-036 Without JOHNSON_STEP_CTRL_IDLE_OFF_EN, phase_out SHALL equal the internal phase register at all times.

Verification
REQ-037 Reset then command dir=1, steps=8, div=0 (WIDTH=4) -> phase_out 1000,1100,1110,1111,0111,0011,0001,0000 on consecutive cycles, done pulse one cycle after last step, steps_left=0.
REQ-038 From 0000, dir=0, steps=3, div=2 -> phase_out 0001, 0011, 0111 at 3-cycle spacing; busy high 9 cycles.
REQ-039 steps=0 command -> no phase change, done pulses on cycle after acceptance, busy never asserted.
REQ-040 steps=10, div=1, abort raised after 3 steps -> abort_ack pulse, no done, steps_left=7, phase frozen, cmd_ready=1 afterwards.
REQ-041 rst driven low mid-move with steps_left=5 -> all outputs at reset values immediately, no done/abort_ack; cmd_valid held high during DONE ignored.
REQ-042 With JOHNSON_STEP_CTRL_IDLE_OFF_EN, forward 2 steps then idle -> phase_out=0000 in IDLE; next forward command starts from internal 1100 -> first step shows 1110.
